// File: rtl/serial_sub_unit.sv
// serial_sub_unit: bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first.
// One full-subtract cell per cycle with a borrow flop; start/busy/done handshake.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           request, sampled only when idle
//   a_in, b_in      minuend / subtrahend, captured at accepted start
//   bin_in          initial borrow-in, captured at accepted start
//   busy            high while bits are being shifted
//   done            one-cycle pulse, result valid
//   diff_out        difference, held until the next result
//   borrow_out      final borrow (unsigned underflow)
//   ovf_out         signed two's-complement overflow
module serial_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic cell_a, cell_b, cell_c;
  logic cell_d, cell_bo;

  // Full-subtract bit-slice on the current LSBs and the borrow flop.
  always_comb begin
    cell_a  = a_sr_q[0];
    cell_b  = b_sr_q[0];
    cell_c  = brw_q;
    cell_d  = cell_a ^ cell_b ^ cell_c;
    cell_bo = (~cell_a & cell_b)
            | (~(cell_a ^ cell_b) & cell_c);
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          brw_d   = bin_in;
          cnt_d   = '0;
          a_msb_d = a_in[WIDTH-1];
          b_msb_d = b_in[WIDTH-1];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {cell_d, res_sr_q[WIDTH-1:1]};
        brw_d    = cell_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          diff_d   = {cell_d, res_sr_q[WIDTH-1:1]};
          borrow_d = cell_bo;
          // Overflow: operand signs differ and result sign
          // differs from the minuend's sign.
          ovf_d    = (a_msb_q != b_msb_q)
                   && (cell_d != a_msb_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;
  assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_serial_sub_unit.sv
// tb_serial_sub_unit: random + directed bench for serial_sub_unit.
// Arithmetic reference model, per-cycle compare, literal pins.
module tb_serial_sub_unit;

  localparam int W = 8;
  localparam int MAXW = 3 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         bin_in = 1'b0;
  logic         busy, done;
  logic [W-1:0] diff_out;
  logic         borrow_out, ovf_out;

  int errors = 0;
  int checks = 0;

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a_in(a_in),
    .b_in(b_in),
    .bin_in(bin_in),
    .busy(busy),
    .done(done),
    .diff_out(diff_out),
    .borrow_out(borrow_out),
    .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: a - b - bin as plain integers.
  function automatic logic [W+1:0] ref_sub(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         bi);
    int ua, ub, sa, sb, r, sr;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    r  = ua - ub - int'(bi);
    sr = sa - sb - int'(bi);
    d  = W'(r);
    bo = (ua < ub + int'(bi));
    ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  // Behavioural model: an op accepted when idle produces its
  // result WIDTH cycles later, then one idle cycle follows.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_a, m_b;
  logic         m_bin;
  logic [W-1:0] m_diff;
  logic         m_borrow, m_ovf;
  logic [W+1:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_r      = ref_sub(m_a, m_b, m_bin);
        m_diff   <= m_r[W-1:0];
        m_borrow <= m_r[W];
        m_ovf    <= m_r[W+1];
        m_done   <= 1'b1;
      end
    end else if (start) begin
      m_a    <= a_in;
      m_b    <= b_in;
      m_bin  <= bin_in;
      m_left <= W;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff_out), 32'(m_diff));
      chk("borrow", 32'(borrow_out), 32'(m_borrow));
      chk("ovf", 32'(ovf_out), 32'(m_ovf));
      chk("busy_done_excl", 32'(busy & done), 32'd0);
    end
  end

  task automatic pulse(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic bi);
    @(negedge clk);
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    bin_in = bi;
    @(negedge clk);
    start  = 1'b0;
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    bin_in = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= MAXW; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic dir_op(input string nm,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic bi,
                        input logic [W-1:0] xd,
                        input logic xb,
                        input logic xo);
    int lat;
    pulse(a, b, bi);
    @(negedge clk);
    wait_done(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    chk({nm, "_diff"}, 32'(diff_out), 32'(xd));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(xb));
    chk({nm, "_ovf"}, 32'(ovf_out), 32'(xo));
    chk({nm, "_model"}, 32'(m_diff), 32'(xd));
    @(negedge clk);
  endtask

  int dn_cyc[$];
  int lat;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff_out), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    dir_op("t1", 8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0);
    dir_op("t2", 8'h05, 8'h0F, 1'b0, 8'hF6, 1'b1, 1'b0);
    dir_op("t3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    dir_op("t4", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Re-pulse start mid-shift with other operands: ignored.
    pulse(8'h33, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'hF0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("t5_diff", 32'(diff_out), 32'h22);
    chk("t5_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Reset after the 4th shift edge aborts the op.
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'h10;
    b_in  = 8'h20;
    @(posedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5r_busy", 32'(busy), 32'd0);
    chk("t5r_done", 32'(done), 32'd0);
    chk("t5r_diff", 32'(diff_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dir_op("t5b", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      pulse(W'($urandom), W'($urandom), 1'($urandom));
      @(negedge clk);
      wait_done(lat);
      chk("rnd_latency", 32'(lat), 32'(W));
      @(negedge clk);
    end

    // Start held high: back-to-back ops with churning operands.
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 60 && dn_cyc.size() < 3; c++) begin
      a_in   = W'($urandom);
      b_in   = W'($urandom);
      bin_in = 1'($urandom);
      @(negedge clk);
      if (done) dn_cyc.push_back(c);
    end
    start = 1'b0;
    chk("t6_count", 32'(dn_cyc.size()), 32'd3);
    if (dn_cyc.size() == 3) begin
      chk("t6_ii0", 32'(dn_cyc[1] - dn_cyc[0]), 32'(W + 2));
      chk("t6_ii1", 32'(dn_cyc[2] - dn_cyc[1]), 32'(W + 2));
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
